// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier: default width, FSM states,
// per-step arithmetic op codes and the Booth pair decoder.
package booth_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult8_if.sv
// Start/done handshake and operand/result bus between the control block
// and the Booth multiplier.
interface booth_mult8_if #(
    parameter int WIDTH = 8
) ();
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_addsub.sv
// Ripple-carry adder/subtractor: sum = a + b (sub=0) or a + ~b + 1 (sub=1).
// The final carry-out is intentionally dropped.
module booth_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);
    logic [N-1:0] bx;
    logic         c;

    always_comb begin
        bx  = b ^ {N{sub}};
        c   = sub;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ bx[i] ^ c;
            c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
        end
    end
endmodule

// File: rtl/booth_mult8.sv
// Sequential signed radix-2 Booth multiplier, one Booth step per clock.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; operands captured on the accepting edge
//   ST_RUN  | one add/sub/nop + arithmetic shift per cycle, count down
//   ST_DONE | product valid, done pulses for this single cycle
module booth_mult8
    import booth_pkg::*;
#(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    booth_mult8_if.slave  bus
);
    // Accumulator carries one guard bit so that A - (-2^(WIDTH-1)) fits.
    localparam int AW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    state_e             state, state_nxt;
    logic [AW-1:0]      acc, mcand, sum;
    logic [AW-1:0]      acc_op, acc_sh;
    logic [WIDTH-1:0]   q, q_sh;
    logic               q_1;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;
    booth_op_e          op;
    logic               accept, last_step;

    assign op = booth_decode(q[0], q_1);

    booth_addsub #(.N(AW)) u_addsub (
        .a   (acc),
        .b   (mcand),
        .sub (op == OP_SUB),
        .sum (sum)
    );

    always_comb begin
        acc_op    = (op == OP_NOP) ? acc : sum;
        acc_sh    = {acc_op[AW-1], acc_op[AW-1:1]};
        q_sh      = {acc_op[0], q[WIDTH-1:1]};
        accept    = (state == ST_IDLE) && bus.start;
        last_step = (state == ST_RUN) && (count == CW'(1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (last_step) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc   <= '0;
                q     <= bus.multiplier;
                q_1   <= 1'b0;
                mcand <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
                count <= CW'(WIDTH);
            end else if (state == ST_RUN) begin
                acc   <= acc_sh;
                q     <= q_sh;
                q_1   <= q[0];
                count <= count - CW'(1);
                // Capture the post-shift result so it is valid while done is high.
                if (last_step)
                    product <= {acc_sh[WIDTH-1:0], q_sh};
            end
        end
    end

    assign bus.busy    = (state == ST_RUN);
    assign bus.done    = (state == ST_DONE);
    assign bus.product = product;
endmodule

// File: tb/tb_booth_mult8.sv
// Self-checking bench for booth_mult8: directed operands, ignored start,
// mid-run reset and back-to-back operation against a queued reference.
module tb_booth_mult8;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   held_err = 0;
    logic [2*W-1:0] last_prod = '0;
    logic [2*W-1:0] exp_q[$];

    booth_mult8_if #(.WIDTH(W)) bus ();

    booth_mult8 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=hung expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
        int pa, pb;
        logic [31:0] p;
        pa = $signed(m);
        pb = $signed(q);
        p  = pa * pb;
        return p[2*W-1:0];
    endfunction

    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input bit push);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        if (push) exp_q.push_back(model(m, q));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Waits for one done pulse; returns the idle cycles seen before busy rose.
    task automatic collect(input string tag, output int idle_cnt);
        int busy_cnt = 0;
        int gap_err  = 0;
        bit seen_busy = 0;
        bit got = 0;
        logic [2*W-1:0] exp;
        idle_cnt = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.busy && bus.done) gap_err++;
            if (bus.done) begin
                got = 1;
            end else begin
                if (bus.product !== last_prod) held_err++;
                if (bus.busy) begin
                    busy_cnt++;
                    seen_busy = 1;
                end else if (seen_busy) begin
                    gap_err++;
                end else begin
                    idle_cnt++;
                end
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_product"}, 32'(bus.product), 32'(exp));
        chk({tag, "_busy_cycles"}, busy_cnt, W);
        chk({tag, "_gap"}, gap_err, 0);
        last_prod = bus.product;
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int dn = 0;
        int bz = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.busy) bz++;
            if (bus.product !== last_prod) held_err++;
        end
        chk({tag, "_no_done"}, dn, 0);
        chk({tag, "_no_busy"}, bz, 0);
    endtask

    initial begin
        int idle;
        logic [W-1:0] rm, rq;

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_product", 32'(bus.product), 32'd0);

        // Directed operand pairs
        issue(8'd3, 8'd5, 1);
        collect("3x5", idle);
        chk("3x5_start_latency", idle, 0);
        chk("3x5_value", 32'(last_prod), 32'h000F);
        issue(8'hF9, 8'h06, 1);
        collect("m7x6", idle);
        chk("m7x6_value", 32'(last_prod), 32'hFFD6);
        issue(8'h7F, 8'h80, 1);
        collect("127xm128", idle);
        chk("127xm128_value", 32'(last_prod), 32'hC080);
        issue(8'h80, 8'h80, 1);
        collect("m128xm128", idle);
        chk("m128xm128_value", 32'(last_prod), 32'h4000);
        issue(8'h00, 8'hFF, 1);
        collect("0xm1", idle);
        chk("0xm1_value", 32'(last_prod), 32'h0000);

        // Start raised while running must be ignored
        issue(8'd3, 8'd5, 1);
        fork
            collect("ignored_start", idle);
            begin
                repeat (3) @(negedge clk);
                bus.start        = 1'b1;
                bus.multiplicand = 8'd2;
                bus.multiplier   = 8'd2;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        chk("ignored_start_value", 32'(last_prod), 32'h000F);
        watch_quiet("ignored_start_after", 12);

        // Reset in the 4th RUN cycle
        issue(8'd9, 8'd9, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_product", 32'(bus.product), 32'd0);
        last_prod = '0;
        watch_quiet("midrst_after", 15);
        issue(8'hFD, 8'hFB, 1);
        collect("after_rst", idle);
        chk("after_rst_value", 32'(last_prod), 32'h000F);

        // Start held high: acceptances every WIDTH+2 edges
        @(negedge clk);
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    rm = W'($urandom);
                    rq = W'($urandom);
                    bus.start        = 1'b1;
                    bus.multiplicand = rm;
                    bus.multiplier   = rq;
                    if (c % (W + 2) == 0) exp_q.push_back(model(rm, rq));
                end
                @(negedge clk);
                bus.start = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    collect($sformatf("b2b%0d", k), idle);
                    chk($sformatf("b2b%0d_idle_gap", k), idle, 1);
                end
            end
        join
        watch_quiet("b2b_after", 12);

        chk("product_held", held_err, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
